soc_nvram_dma: RTL and testbench



---
 rtl/soc_nvram_dma.sv | 135 +++++++++++++
 tb/tb_soc_nvram_dma.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_nvram_dma.sv
// soc_nvram_dma: word-copy engine for the system memory port protocol.
// Copies word_count 32-bit words from a source responder (combinational
// read) to a destination responder (write on clock edge), 2 cycles per word.
module soc_nvram_dma #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [31:0]            src_base,
    input  logic [31:0]            dst_base,
    input  logic [COUNT_WIDTH-1:0] word_count,
    input  logic                   abort,
    output logic [31:0]            src_addr,
    input  logic [DATA_WIDTH-1:0]  src_data,
    output logic                   dst_we,
    output logic [31:0]            dst_addr,
    output logic [DATA_WIDTH-1:0]  dst_data,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic [COUNT_WIDTH-1:0] words_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            src_ptr_q, src_ptr_d;
    logic [31:0]            dst_ptr_q, dst_ptr_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic [31:0]            dst_addr_q, dst_addr_d;
    logic [DATA_WIDTH-1:0]  dst_data_q, dst_data_d;
    logic [COUNT_WIDTH-1:0] words_done_q, words_done_d;
    logic                   aborted_q, aborted_d;

    // Byte-offset bits of the bases are forced to zero and never used.
    logic unused_base_lsbs;
    assign unused_base_lsbs = ^{src_base[1:0], dst_base[1:0]};

    // State and datapath registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            src_ptr_q    <= '0;
            dst_ptr_q    <= '0;
            remaining_q  <= '0;
            dst_addr_q   <= '0;
            dst_data_q   <= '0;
            words_done_q <= '0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_ptr_q    <= src_ptr_d;
            dst_ptr_q    <= dst_ptr_d;
            remaining_q  <= remaining_d;
            dst_addr_q   <= dst_addr_d;
            dst_data_q   <= dst_data_d;
            words_done_q <= words_done_d;
            aborted_q    <= aborted_d;
        end
    end

    // Next-state and datapath update logic.
    // The destination address/data registers are loaded on the READ->WRITE
    // edge, so they present the write in WRITE and hold it afterwards.
    always_comb begin
        state_d      = state_q;
        src_ptr_d    = src_ptr_q;
        dst_ptr_d    = dst_ptr_q;
        remaining_d  = remaining_q;
        dst_addr_d   = dst_addr_q;
        dst_data_d   = dst_data_q;
        words_done_d = words_done_q;
        aborted_d    = aborted_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_ptr_d    = {src_base[31:2], 2'b00};
                    dst_ptr_d    = {dst_base[31:2], 2'b00};
                    remaining_d  = word_count;
                    words_done_d = '0;
                    aborted_d    = 1'b0;
                    state_d      = (word_count != '0) ? S_READ : S_DONE;
                end
            end
            S_READ: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    dst_data_d = src_data;
                    dst_addr_d = dst_ptr_q;
                    src_ptr_d  = src_ptr_q + 32'd4;
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                dst_ptr_d    = dst_ptr_q + 32'd4;
                words_done_d = words_done_q + COUNT_WIDTH'(1);
                remaining_d  = remaining_q - COUNT_WIDTH'(1);
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else if (remaining_q == COUNT_WIDTH'(1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign src_addr   = (state_q == S_READ) ? src_ptr_q : '0;
    assign dst_we     = (state_q == S_WRITE);
    assign dst_addr   = dst_addr_q;
    assign dst_data   = dst_data_q;
    assign busy       = (state_q == S_READ) || (state_q == S_WRITE);
    assign done       = (state_q == S_DONE);
    assign aborted    = aborted_q;
    assign words_done = words_done_q;

endmodule

// File: tb/tb_soc_nvram_dma.sv
// Scoreboard bench for soc_nvram_dma: a transaction-level model predicts
// every destination write and done pulse; a monitor checks them as they occur.
module tb_soc_nvram_dma;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   src_base = '0;
    logic [31:0]   dst_base = '0;
    logic [CW-1:0] word_count = '0;
    logic          abort = 1'b0;
    logic [31:0]   src_addr;
    logic [DW-1:0] src_data;
    logic          dst_we;
    logic [31:0]   dst_addr;
    logic [DW-1:0] dst_data;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [CW-1:0] words_done;

    soc_nvram_dma #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src_base   (src_base),
        .dst_base   (dst_base),
        .word_count (word_count),
        .abort      (abort),
        .src_addr   (src_addr),
        .src_data   (src_data),
        .dst_we     (dst_we),
        .dst_addr   (dst_addr),
        .dst_data   (dst_data),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .words_done (words_done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Source responder contents: three fixed words, hashed data elsewhere.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h100: return 32'h11111111;
            32'h104: return 32'h22222222;
            32'h108: return 32'h33333333;
            default: return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
        endcase
    endfunction

    assign src_data = mem_rd(src_addr);

    typedef struct {
        int unsigned c;
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;
    typedef struct {
        int unsigned c;
        logic [CW-1:0] wd;
        logic ab;
    } dn_t;

    wr_t wq[$];
    dn_t dq[$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model. Cycle offsets are relative to the first cycle after
    // the start is accepted (offset o = cycle-1): word i is written at
    // o=2i+1, done at o=2n (o=0 for empty). An abort in cycle c (1..2n)
    // ends with done in cycle c+1; odd c is a read, even c a write.
    task automatic model(input int unsigned a0, input logic [31:0] s, input logic [31:0] d,
                         input int n, input int ac, output int last);
        int nw;
        logic ab;
        wr_t w;
        dn_t e;
        s = s & ~32'd3;
        d = d & ~32'd3;
        if (n == 0) begin
            nw = 0; last = 0; ab = 1'b0;
        end else if (ac == 0) begin
            nw = n; last = 2 * n; ab = 1'b0;
        end else begin
            last = ac; ab = 1'b1;
            nw = (ac % 2 == 1) ? (ac - 1) / 2 : ac / 2;
        end
        for (int i = 0; i < nw; i++) begin
            w.c = a0 + 2 * i + 1;
            w.a = d + 32'(4 * i);
            w.d = mem_rd(s + 32'(4 * i));
            wq.push_back(w);
        end
        e.c = a0 + last;
        e.wd = CW'(nw);
        e.ab = ab;
        dq.push_back(e);
    endtask

    // Issue one command; ac = abort cycle (0 none), stray = offset of an
    // extra start pulse that must be ignored (-1 none).
    task automatic run_cmd(input logic [31:0] s, input logic [31:0] d, input int n,
                           input int ac, input int stray);
        int unsigned a0;
        int last;
        @(posedge clk); #1;
        a0 = cyc + 1;
        model(a0, s, d, n, ac, last);
        start = 1'b1; src_base = s; dst_base = d; word_count = CW'(n);
        @(posedge clk); #1;
        start = 1'b0;
        src_base = $urandom; dst_base = $urandom; word_count = CW'($urandom);
        for (int o = 0; o <= last; o++) begin
            abort = (ac != 0) && (o == ac - 1);
            start = (o == stray);
            @(posedge clk); #1;
        end
        abort = 1'b0; start = 1'b0;
        abort = ($urandom_range(0, 3) == 0);
        @(posedge clk); #1;
        abort = 1'b0;
    endtask

    // Monitor: every write and done pulse must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (dst_we) begin
                if (wq.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_write: got addr %0h expected no write (cyc %0d)", dst_addr, cyc);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("write_cycle", 64'(cyc), 64'(e.c));
                    chk("write_addr", 64'(dst_addr), 64'(e.a));
                    chk("write_data", 64'(dst_data), 64'(e.d));
                    chk("busy_in_write", 64'(busy), 64'd1);
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_done: got done=1 expected 0 (cyc %0d)", cyc);
                end else begin
                    dn_t e;
                    e = dq.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.c));
                    chk("done_words", 64'(words_done), 64'(e.wd));
                    chk("done_aborted", 64'(aborted), 64'(e.ab));
                    chk("busy_in_done", 64'(busy), 64'd0);
                end
            end
        end
    end

    initial begin
        int unsigned a0;
        int n, ac, stray;
        logic [31:0] s, d;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dst_we", 64'(dst_we), 64'd0);
        chk("rst_src_addr", 64'(src_addr), 64'd0);
        chk("rst_dst_addr", 64'(dst_addr), 64'd0);
        chk("rst_dst_data", 64'(dst_data), 64'd0);
        chk("rst_aborted", 64'(aborted), 64'd0);
        chk("rst_words_done", 64'(words_done), 64'd0);
        rst = 1'b0;

        run_cmd(32'h100, 32'h2000, 3, 0, -1);        // basic copy
        run_cmd(32'h40, 32'h3000, 0, 0, -1);         // zero length
        run_cmd(32'h200, 32'h4000, 5, 4, -1);        // abort in write of second word
        run_cmd(32'h200, 32'h4000, 5, 5, -1);        // abort in read of third word
        run_cmd(32'h103, 32'hFFFFFFFC, 2, 0, -1);    // misaligned source, dest wrap
        run_cmd(32'h300, 32'h5000, 4, 0, 3);         // start while busy ignored
        run_cmd(32'h300, 32'h5100, 2, 4, -1);        // abort on final write

        // Reset during cycle 3 of a 4-word copy: only word 0 is written.
        @(posedge clk); #1;
        a0 = cyc + 1;
        begin
            wr_t w;
            w.c = a0 + 1; w.a = 32'h6000; w.d = mem_rd(32'h700);
            wq.push_back(w);
        end
        start = 1'b1; src_base = 32'h700; dst_base = 32'h6000; word_count = CW'(4);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_dst_we", 64'(dst_we), 64'd0);
        chk("post_rst_done", 64'(done), 64'd0);
        chk("post_rst_words_done", 64'(words_done), 64'd0);

        run_cmd(32'h100, 32'h7000, 3, 0, -1);        // normal run after reset

        for (int k = 0; k < 40; k++) begin
            n = $urandom_range(0, 6);
            s = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15)) : $urandom;
            d = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15)) : $urandom;
            ac = (n != 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2 * n)) : 0;
            stray = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 2 * n)) : -1;
            run_cmd(s, d, n, ac, stray);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("writes_outstanding", 64'(wq.size()), 64'd0);
        chk("dones_outstanding", 64'(dq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
